// File: rtl/eth_pkg.sv
// Shared RMII receive definitions: FSM states, framing constants and the
// helper that places header dibits into a 48-bit destination MAC.
package eth_pkg;

  typedef enum logic [2:0] {
    StWaitIdle,
    StIdle,
    StPreamble,
    StHeader,
    StPayload,
    StDrop
  } rx_state_e;

  localparam logic [1:0]  PREAMBLE_DIBIT = 2'b01;
  localparam logic [1:0]  SFD_DIBIT      = 2'b11;
  localparam int unsigned HEADER_DIBITS  = 56;
  localparam int unsigned MAC_DIBITS     = 24;
  localparam int unsigned FCS_DIBITS     = 16;
  localparam logic [47:0] BROADCAST_MAC  = 48'hFFFF_FFFF_FFFF;

  // Bit offset of header dibit k: bytes arrive MSB byte first, dibits LSB first.
  function automatic logic [5:0] mac_dibit_pos(input logic [4:0] k);
    return 6'd40 - {k[4:2], 3'b000} + {3'b000, k[1:0], 1'b0};
  endfunction

endpackage

// File: rtl/dibit_fcs_delay.sv
// Holds the last 16 payload dibits back as the FCS window; each byte that
// leaves the window is re-emitted MSB dibit first on four consecutive cycles.
module dibit_fcs_delay
  import eth_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  logic       flush_i,
  input  logic       end_i,
  input  logic [1:0] dibit_i,
  output logic       valid_o,
  output logic [1:0] dibit_o,
  output logic       done_o
);

  localparam int unsigned LineW = 2 * FCS_DIBITS;

  logic [LineW-1:0] line_q, line_d;
  logic [4:0]       fill_q, fill_d;
  logic [1:0]       phase_q, phase_d;
  logic [5:0]       hold_q, hold_d;
  logic [5:0]       out_q, out_d;
  logic [1:0]       left_q, left_d;
  logic             valid_q, valid_d;
  logic [1:0]       dibit_q, dibit_d;
  logic             done_q, done_d;

  logic       full;
  logic       load;
  logic [1:0] oldest;

  assign oldest = line_q[LineW-1 -: 2];
  assign full   = (fill_q == 5'(FCS_DIBITS));
  // The dibit leaving a full window is confirmed; the fourth of a byte completes it.
  assign load   = push_i && full && (phase_q == 2'd3);

  always_comb begin
    line_d  = line_q;
    fill_d  = fill_q;
    phase_d = phase_q;
    hold_d  = hold_q;
    if (flush_i || end_i) begin
      line_d  = '0;
      fill_d  = '0;
      phase_d = '0;
      hold_d  = '0;
    end else if (push_i) begin
      line_d = {line_q[LineW-3:0], dibit_i};
      if (!full) begin
        fill_d = fill_q + 5'd1;
      end else begin
        phase_d = phase_q + 2'd1;
        if (phase_q != 2'd3) begin
          hold_d[{phase_q, 1'b0} +: 2] = oldest;
        end
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    dibit_d = dibit_q;
    out_d   = out_q;
    left_d  = left_q;
    done_d  = 1'b0;
    if (load) begin
      valid_d = 1'b1;
      dibit_d = oldest;
      out_d   = hold_q;
      left_d  = 2'd3;
    end else if (valid_q && (left_q != 2'd0)) begin
      dibit_d = out_q[5:4];
      out_d   = {out_q[3:0], 2'b00};
      left_d  = left_q - 2'd1;
    end else if (valid_q) begin
      valid_d = 1'b0;
      dibit_d = 2'b00;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      line_q  <= '0;
      fill_q  <= '0;
      phase_q <= '0;
      hold_q  <= '0;
      out_q   <= '0;
      left_q  <= '0;
      valid_q <= 1'b0;
      dibit_q <= 2'b00;
      done_q  <= 1'b0;
    end else begin
      line_q  <= line_d;
      fill_q  <= fill_d;
      phase_q <= phase_d;
      hold_q  <= hold_d;
      out_q   <= out_d;
      left_q  <= left_d;
      valid_q <= valid_d;
      dibit_q <= dibit_d;
      done_q  <= done_d;
    end
  end

  assign valid_o = valid_q;
  assign dibit_o = dibit_q;
  assign done_o  = done_q;

endmodule

// File: rtl/rmii_payload_extractor.sv
// RMII receive front end: preamble/SFD lock, header strip, FCS strip, dibit reorder.
// Destination filtering is built only when MAC_FILTER_EN is defined.
module rmii_payload_extractor
  import eth_pkg::*;
#(
  parameter logic [47:0] MAC_ADDR = 48'h02_00_00_00_00_01
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       crsdv,
  input  logic [1:0] rxd,
  output logic       axiov,
  output logic [1:0] axiod,
  output logic       frame_done,
  output logic       mac_drop
);

  rx_state_e  state_q, state_d;
  logic [5:0] hdr_cnt_q, hdr_cnt_d;
  logic       push;
  logic       flush;
  logic       frame_end;
  logic       reject;

`ifdef MAC_FILTER_EN
  logic [47:0] dest_q, dest_d;
  logic        mac_drop_q;
  logic        at_last_mac;

  assign at_last_mac = (state_q == StHeader) && crsdv && (hdr_cnt_q == 6'(MAC_DIBITS - 1));

  always_comb begin
    dest_d = dest_q;
    if ((state_q == StHeader) && crsdv && (hdr_cnt_q < 6'(MAC_DIBITS))) begin
      dest_d[mac_dibit_pos(hdr_cnt_q[4:0]) +: 2] = rxd;
    end
  end

  // Compare includes the dibit being sampled now, so the decision lands on dibit 23.
  assign reject = at_last_mac && (dest_d != MAC_ADDR) && (dest_d != BROADCAST_MAC);

  always_ff @(posedge clk) begin
    if (rst) begin
      dest_q     <= '0;
      mac_drop_q <= 1'b0;
    end else begin
      dest_q     <= dest_d;
      mac_drop_q <= reject;
    end
  end

  assign mac_drop = mac_drop_q;
`else
  assign reject   = 1'b0;
  assign mac_drop = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    hdr_cnt_d = hdr_cnt_q;
    push      = 1'b0;
    flush     = 1'b0;
    frame_end = 1'b0;
    unique case (state_q)
      StWaitIdle: begin
        if (!crsdv) state_d = StIdle;
      end
      StIdle: begin
        if (crsdv) state_d = (rxd == PREAMBLE_DIBIT) ? StPreamble : StDrop;
      end
      StPreamble: begin
        if (!crsdv) begin
          state_d = StIdle;
        end else if (rxd == SFD_DIBIT) begin
          state_d   = StHeader;
          hdr_cnt_d = '0;
          flush     = 1'b1;
        end else if (rxd != PREAMBLE_DIBIT) begin
          state_d = StDrop;
        end
      end
      StHeader: begin
        if (!crsdv) begin
          state_d = StIdle;
        end else if (reject) begin
          state_d = StDrop;
        end else if (hdr_cnt_q == 6'(HEADER_DIBITS - 1)) begin
          state_d   = StPayload;
          hdr_cnt_d = '0;
        end else begin
          hdr_cnt_d = hdr_cnt_q + 6'd1;
        end
      end
      StPayload: begin
        if (crsdv) begin
          push = 1'b1;
        end else begin
          frame_end = 1'b1;
          state_d   = StIdle;
        end
      end
      StDrop: begin
        if (!crsdv) state_d = StIdle;
      end
      default: state_d = StWaitIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StWaitIdle;
      hdr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      hdr_cnt_q <= hdr_cnt_d;
    end
  end

  dibit_fcs_delay u_fcs_delay (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push),
    .flush_i (flush),
    .end_i   (frame_end),
    .dibit_i (rxd),
    .valid_o (axiov),
    .dibit_o (axiod),
    .done_o  (frame_done)
  );

endmodule

// File: tb/tb_rmii_payload_extractor.sv
// Self-checking bench for rmii_payload_extractor: directed frames from the test
// plan plus random frames, checked against a byte-level payload model.
module tb_rmii_payload_extractor;

  localparam logic [47:0] MY_MAC    = 48'h02_00_00_00_00_01;
  localparam logic [47:0] BCAST     = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] OTHER_MAC = 48'h02_00_00_00_00_02;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       crsdv = 1'b0;
  logic [1:0] rxd   = 2'b00;
  logic       axiov;
  logic [1:0] axiod;
  logic       frame_done;
  logic       mac_drop;

  rmii_payload_extractor #(
    .MAC_ADDR (MY_MAC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .crsdv      (crsdv),
    .rxd        (rxd),
    .axiov      (axiov),
    .axiod      (axiod),
    .frame_done (frame_done),
    .mac_drop   (mac_drop)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: monotonic records sampled on the falling edge.
  logic [1:0] got_q[$];
  int         gcyc_q[$];
  int         bursts = 0, done_n = 0, done_cyc = -1, drop_n = 0, drop_cyc = -1, zero_viol = 0;
  logic       prev_v = 1'b0;

  always @(negedge clk) begin
    if (axiov === 1'b1) begin
      if (prev_v !== 1'b1) bursts <= bursts + 1;
      got_q.push_back(axiod);
      gcyc_q.push_back(cyc);
    end else if (axiod !== 2'b00) begin
      zero_viol <= zero_viol + 1;
    end
    if (frame_done === 1'b1) begin
      done_n   <= done_n + 1;
      done_cyc <= cyc;
    end
    if (mac_drop === 1'b1) begin
      drop_n   <= drop_n + 1;
      drop_cyc <= cyc;
    end
    prev_v <= axiov;
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  logic [7:0] pay_q[$];
  logic [1:0] exp_q[$];
  int         drv_edge, h0, e0, rst_edge;
  int         s_g, s_b, s_d, s_dr, s_z;

  task automatic drive(input logic [1:0] d);
    @(negedge clk);
    crsdv    = 1'b1;
    rxd      = d;
    drv_edge = cyc + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      crsdv = 1'b0;
      rxd   = 2'b00;
    end
  endtask

  task automatic snap();
    s_g  = got_q.size();
    s_b  = bursts;
    s_d  = done_n;
    s_dr = drop_n;
    s_z  = zero_viol;
  endtask

  // runt_at: header dibit index at which carrier drops; abort_at: payload dibit
  // index on which rst is asserted for one cycle while carrier stays high.
  task automatic send_frame(input logic [47:0] dest, input int partial, input int runt_at,
                            input int abort_at);
    logic [7:0] b;
    int         idx;
    for (int i = 0; i < 31; i++) drive(2'b01);
    drive(2'b11);
    for (int i = 0; i < 14; i++) begin
      b = (i < 6) ? dest[47 - 8*i -: 8] : 8'($urandom);
      for (int k = 0; k < 4; k++) begin
        idx = 4*i + k;
        if (idx == runt_at) return;
        drive(b[2*k +: 2]);
        if (idx == 0) h0 = drv_edge;
      end
    end
    for (int j = 0; j < pay_q.size(); j++) begin
      b = pay_q[j];
      for (int k = 0; k < 4; k++) begin
        idx = 4*j + k;
        drive(b[2*k +: 2]);
        if (idx == 0) e0 = drv_edge;
        if (rst) begin
          check("rst_mid.axiov", {63'd0, axiov}, 64'd0);
          check("rst_mid.axiod", {62'd0, axiod}, 64'd0);
          check("rst_mid.frame_done", {63'd0, frame_done}, 64'd0);
          rst = 1'b0;
        end
        if (idx == abort_at) begin
          rst      = 1'b1;
          rst_edge = drv_edge;
        end
      end
    end
    for (int j = 0; j < 4; j++) begin
      b = 8'($urandom);
      for (int k = 0; k < 4; k++) drive(b[2*k +: 2]);
    end
    for (int k = 0; k < partial; k++) drive(2'($urandom));
  endtask

  task automatic check_frame(input string tag, input logic [47:0] dest, input bit reaches);
    bit accept;
    bit drop_exp;
    int n_exp, n_got, n_min;
    accept   = 1'b1;
    drop_exp = 1'b0;
`ifdef MAC_FILTER_EN
    accept   = (dest == MY_MAC) || (dest == BCAST);
    drop_exp = !accept && reaches;
`endif
    exp_q.delete();
    if (accept && reaches) begin
      foreach (pay_q[j]) begin
        for (int k = 0; k < 4; k++) exp_q.push_back(2'((pay_q[j] >> (6 - 2*k)) & 8'h03));
      end
    end
    n_exp = exp_q.size();
    n_got = got_q.size() - s_g;
    n_min = (n_got < n_exp) ? n_got : n_exp;
    check($sformatf("%s.count", tag), 64'(n_got), 64'(n_exp));
    for (int i = 0; i < n_min; i++)
      check($sformatf("%s.dibit%0d", tag, i), {62'd0, got_q[s_g + i]}, {62'd0, exp_q[i]});
    check($sformatf("%s.bursts", tag), 64'(bursts - s_b), (n_exp > 0) ? 64'd1 : 64'd0);
    check($sformatf("%s.done_n", tag), 64'(done_n - s_d), (n_exp > 0) ? 64'd1 : 64'd0);
    check($sformatf("%s.drop_n", tag), 64'(drop_n - s_dr), drop_exp ? 64'd1 : 64'd0);
    check($sformatf("%s.axiod_idle", tag), 64'(zero_viol - s_z), 64'd0);
    if (n_exp > 0 && n_got > 0) begin
      check($sformatf("%s.first_cyc", tag), 64'(gcyc_q[s_g]), 64'(e0 + 19));
      check($sformatf("%s.last_cyc", tag), 64'(gcyc_q[got_q.size() - 1]), 64'(e0 + n_exp + 18));
      check($sformatf("%s.done_cyc", tag), 64'(done_cyc), 64'(e0 + n_exp + 19));
    end
    if (drop_exp) check($sformatf("%s.drop_cyc", tag), 64'(drop_cyc), 64'(h0 + 23));
  endtask

  task automatic run(input string tag, input logic [47:0] dest, input int partial);
    snap();
    send_frame(dest, partial, -1, -1);
    idle(12);
    check_frame(tag, dest, 1'b1);
  endtask

  logic [1:0] plan_a[16] = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd3, 2'd1, 2'd0,
                             2'd1, 2'd1, 2'd1, 2'd2, 2'd1, 2'd3, 2'd2, 2'd0};
  logic [1:0] plan_b[4]  = '{2'd2, 2'd2, 2'd1, 2'd1};

  initial begin
    logic [47:0] dest;
    int          late;
    int          n;

    repeat (3) @(negedge clk);
    check("reset.axiov", {63'd0, axiov}, 64'd0);
    check("reset.axiod", {62'd0, axiod}, 64'd0);
    check("reset.frame_done", {63'd0, frame_done}, 64'd0);
    check("reset.mac_drop", {63'd0, mac_drop}, 64'd0);
    rst = 1'b0;
    idle(4);

    pay_q = '{8'h12, 8'h34, 8'h56, 8'h78};
    run("own4", MY_MAC, 0);
    for (int i = 0; i < 16; i++)
      check($sformatf("own4.plan%0d", i), {62'd0, got_q[got_q.size() - 16 + i]},
            {62'd0, plan_a[i]});

    run("other_mac", OTHER_MAC, 0);

    pay_q = '{8'hA5};
    run("bcast1", BCAST, 1);
    for (int i = 0; i < 4; i++)
      check($sformatf("bcast1.plan%0d", i), {62'd0, got_q[got_q.size() - 4 + i]},
            {62'd0, plan_b[i]});

    pay_q.delete();
    run("empty", MY_MAC, 2);

    pay_q = '{8'h11, 8'h22, 8'h33};
    snap();
    send_frame(MY_MAC, 0, 40, -1);
    idle(48);
    check_frame("runt", MY_MAC, 1'b0);
    pay_q = '{8'hC3, 8'h3C, 8'h0F, 8'hF0, 8'h99};
    run("after_runt", MY_MAC, 0);

    pay_q.delete();
    for (int i = 0; i < 20; i++) pay_q.push_back(8'($urandom));
    snap();
    send_frame(MY_MAC, 0, -1, 40);
    idle(12);
    late = 0;
    for (int i = s_g; i < got_q.size(); i++) if (gcyc_q[i] >= rst_edge) late++;
    check("rst_mid.some_output", (got_q.size() > s_g) ? 64'd1 : 64'd0, 64'd1);
    check("rst_mid.late_axiov", 64'(late), 64'd0);
    check("rst_mid.done_n", 64'(done_n - s_d), 64'd0);
    pay_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run("after_rst", MY_MAC, 3);

    for (int f = 0; f < 8; f++) begin
      n = $urandom_range(1, 12);
      pay_q.delete();
      for (int i = 0; i < n; i++) pay_q.push_back(8'($urandom));
      case ($urandom_range(0, 2))
        0:       dest = MY_MAC;
        1:       dest = BCAST;
        default: dest = {16'($urandom), 32'($urandom)};
      endcase
      run($sformatf("rand%0d", f), dest, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rmii_payload_extractor.md
# rmii_payload_extractor

Front-end receive stage between the RMII PHY pins and the image/audio splitter. Locks onto preamble/SFD, filters on destination MAC, discards the 14-byte Ethernet header and the trailing 4-byte FCS, and re-orders each payload byte from LSB-dibit-first (wire order) to MSB-dibit-first. The output is one contiguous `axiov` burst per accepted frame, which is the framing the splitter relies on: `axiov` low means packet boundary.

## Interface
- `MAC_ADDR`, default 48'h02_00_00_00_00_01: station address. `[47:40]` is the first byte on the wire.
- `clk`  in  1  50 MHz RMII reference clock.
- `rst`  in  1  Synchronous reset, active-high.
- `crsdv`  in  1  RMII carrier-sense/data-valid.
- `rxd`  in  2  RMII receive dibit. LSB dibit of each byte first.
- `axiov`  out  1  Payload dibit valid. Contiguous for the whole payload.
- `axiod`  out  2  Payload dibit, MSB dibit of each byte first.
- `frame_done`  out  1  One-cycle pulse on the cycle after the last `axiov`.
- `mac_drop`  out  1  One-cycle pulse when a frame is rejected by the MAC filter.

## Operation
- States: `WAIT_IDLE`, `IDLE`, `PREAMBLE`, `HEADER`, `PAYLOAD`, `DROP`.
- `WAIT_IDLE`: reset state. Leave to `IDLE` when `crsdv` is sampled low. This prevents mid-frame locking after reset.
- `IDLE`: `crsdv`=1 and `rxd`=01 goes to `PREAMBLE`. `crsdv`=1 with any other `rxd` goes to `DROP`.
- `PREAMBLE`:
  - `rxd`=01: stay.
  - `rxd`=11 (SFD tail): go to `HEADER`, clear the dibit counter.
  - Any other value: go to `DROP`.
  - `crsdv`=0: go to `IDLE`.
- `HEADER`: count 56 dibits.
  - Dibits 0–23 assemble the destination MAC, LSB dibit first within each byte.
  - At dibit 23, compare against `MAC_ADDR` and 48'hFFFF_FFFF_FFFF, as selected by the Configuration section.
  - Dibits 24–55 (source MAC, ethertype) are discarded.
  - After dibit 55, go to `PAYLOAD`.
  - `crsdv`=0 goes to `IDLE` with no output.
- `PAYLOAD`:
  - Every dibit enters a 16-dibit FCS delay line.
  - Once 4 more complete bytes have followed a payload byte, that byte is confirmed and forwarded.
  - `crsdv`=0 goes to `IDLE`. The 16 dibits still held are the FCS and are discarded, as is any partial trailing byte (dibit count not a multiple of 4).
- `DROP`: ignore input until `crsdv`=0, then go to `IDLE`.
- Byte reorder: a confirmed byte made of wire dibits d0..d3 is emitted as d3, d2, d1, d0 on 4 consecutive cycles.
- A drain of up to 3 cycles continues after `crsdv` falls. It must complete even if `IDLE` sees a new preamble meanwhile; preamble produces no output.
- Frames whose payload is shorter than 1 byte (after FCS) produce no `axiov` and no `frame_done`.

## Timing
- Reset values: `axiov`=0, `axiod`=0, `frame_done`=0, `mac_drop`=0. Delay line and counters cleared.
- Reset mid-frame:
  - Outputs go low on the next cycle.
  - Any in-flight bytes are lost and no `frame_done` is issued.
  - State becomes `WAIT_IDLE`.
- All outputs are registered.
- Let E0 be the edge that samples payload dibit 0. Byte j's dibits d3, d2, d1, d0 are driven from edges E0+4j+19, +20, +21, +22.
- First `axiov` follows E0+19, giving 19 cycles of latency.
- `axiov` deasserts, and `frame_done` pulses, one cycle after the last byte's d0.
- `mac_drop` pulses one cycle after the edge that samples header dibit 23.
- `axiod` holds 0 while `axiov`=0.

## Configuration
- `MAC_FILTER_EN` defined:
  - Frames whose destination is neither `MAC_ADDR` nor broadcast go to `DROP` and pulse `mac_drop`.
- Not defined:
  - Every frame is accepted.
  - `mac_drop` is tied to 0.
  - `MAC_ADDR` is unused, and no destination-MAC register or comparator is built.

## Structure
- Shared package `eth_pkg` holds:
  - The state enum.
  - `PREAMBLE_DIBIT`=2'b01 and `SFD_DIBIT`=2'b11.
  - `HEADER_DIBITS`=56, `MAC_DIBITS`=24, `FCS_DIBITS`=16.
  - `BROADCAST_MAC`.
- Sub-module `dibit_fcs_delay` contains the 16-dibit delay line, the fill counter and the 4-dibit reorder/output register, including the drain. It takes push/flush/end inputs from the FSM.

## Test plan
- Frame to `MAC_ADDR` with a 4-byte payload 0x12,0x34,0x56,0x78 plus FCS:
  - `axiod` = 00,01,00,10 / 00,11,01,00 / 01,01,01,10 / 01,11,10,00 over 16 contiguous `axiov` cycles.
  - First `axiov` at E0+19; `frame_done` after the 16th.
- Destination 48'h02_00_00_00_00_02 with `MAC_FILTER_EN` defined: `mac_drop` pulses once; no `axiov`.
- Same frame without `MAC_FILTER_EN`: payload is forwarded normally.
- Broadcast frame with a 1-byte payload 0xA5: exactly 4 `axiov` cycles, `axiod` 10,10,01,01.
- Runt frame with `crsdv` dropping at header dibit 40: no output, no pulses. A following valid frame after a 48-cycle gap is forwarded intact.
- `rst` asserted mid-payload while `crsdv` stays high: outputs 0 next cycle, no `frame_done`, and the rest of that frame is ignored. The next frame is forwarded normally.
